// File: rtl/bist_ctrl_gen_if.sv
// Handshake and CUT-facing bundle of the generic BIST controller.
// BIST_SIG_OUT_EN adds the live MISR signature to the bundle.
interface bist_ctrl_gen_if #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2
`ifdef BIST_SIG_OUT_EN
  , parameter int MISR_W = 16
`endif
);
  logic             bist_start;
  logic [N_OUT-1:0] cut_out;
  logic [N_IN-1:0]  test_in;
  logic             bist_mode;
  logic             bist_end;
  logic             pass_fail;
`ifdef BIST_SIG_OUT_EN
  logic [MISR_W-1:0] signature;

  modport master (output bist_start, cut_out,
                  input  test_in, bist_mode, bist_end, pass_fail, signature);
  modport slave  (input  bist_start, cut_out,
                  output test_in, bist_mode, bist_end, pass_fail, signature);
`else
  modport master (output bist_start, cut_out,
                  input  test_in, bist_mode, bist_end, pass_fail);
  modport slave  (input  bist_start, cut_out,
                  output test_in, bist_mode, bist_end, pass_fail);
`endif
endinterface

// File: rtl/bist_ctrl_gen.sv
// Generic BIST engine: Galois LFSR stimulus, MISR response compaction, golden compare.
// Optional feature macro BIST_SIG_OUT_EN exposes the MISR as bus.signature.
module bist_ctrl_gen #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter int                N_IN      = 3,
  parameter int                N_OUT     = 2,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
  parameter int                N_PAT     = 1000,
  parameter int                FLUSH     = 4,
  parameter logic [MISR_W-1:0] GOLDEN    = 16'h0000
) (
  input  logic           CLK,
  input  logic           RST,
  bist_ctrl_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RUN, S_FLUSH, S_CHECK, S_DONE
  } state_t;

  localparam int CNT_W = $clog2(N_PAT + 1);
  localparam int FL_W  = (FLUSH > 0) ? $clog2(FLUSH + 1) : 1;
  localparam logic [CNT_W-1:0]  PAT_LAST = CNT_W'(N_PAT - 1);
  localparam logic [FL_W-1:0]   FL_LAST  = FL_W'((FLUSH > 0) ? FLUSH - 1 : 0);
  // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  state_t            state, state_d;
  logic              start_q;
  logic [LFSR_W-1:0] lfsr, lfsr_d, lfsr_step;
  logic [MISR_W-1:0] misr, misr_d, misr_step;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [FL_W-1:0]   fcnt, fcnt_d;
  logic [N_IN-1:0]   test_in_q, test_in_d;
  logic              mode_q, mode_d;
  logic              end_q, end_d;
  logic              pf_q, pf_d;
  logic [N_OUT-1:0]  cut_s;
  logic              rise;

  assign cut_s = bus.cut_out;
  assign rise  = bus.bist_start & ~start_q;

  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
  assign misr_step = {misr[MISR_W-2:0], 1'b0}
                   ^ (misr[MISR_W-1] ? MISR_POLY : '0)
                   ^ MISR_W'(cut_s);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case can leave one unassigned and infer a latch.
    state_d   = state;
    lfsr_d    = lfsr;
    misr_d    = misr;
    cnt_d     = cnt;
    fcnt_d    = fcnt;
    test_in_d = test_in_q;
    mode_d    = mode_q;
    end_d     = end_q;
    pf_d      = pf_q;

    case (state)
      S_IDLE, S_DONE: begin
        if (rise) begin
          state_d = S_INIT;
          mode_d  = 1'b1;
        end
      end
      S_INIT: begin
        lfsr_d  = SEED_EFF;
        misr_d  = '0;
        cnt_d   = '0;
        fcnt_d  = '0;
        end_d   = 1'b0;
        pf_d    = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        lfsr_d    = lfsr_step;
        test_in_d = lfsr[N_IN-1:0];
        misr_d    = misr_step;
        cnt_d     = cnt + CNT_W'(1);
        if (cnt == PAT_LAST) state_d = (FLUSH > 0) ? S_FLUSH : S_CHECK;
      end
      S_FLUSH: begin
        // Zero stimulus drains the CUT pipeline while its tail is still compacted.
        test_in_d = '0;
        misr_d    = misr_step;
        fcnt_d    = fcnt + FL_W'(1);
        if (fcnt == FL_LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        end_d   = 1'b1;
        pf_d    = (misr == GOLDEN);
        mode_d  = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      lfsr      <= SEED_EFF;
      misr      <= '0;
      cnt       <= '0;
      fcnt      <= '0;
      test_in_q <= '0;
      mode_q    <= 1'b0;
      end_q     <= 1'b0;
      pf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values; the stimulus taking the old LFSR state relies on it.
      state     <= state_d;
      start_q   <= bus.bist_start;
      lfsr      <= lfsr_d;
      misr      <= misr_d;
      cnt       <= cnt_d;
      fcnt      <= fcnt_d;
      test_in_q <= test_in_d;
      mode_q    <= mode_d;
      end_q     <= end_d;
      pf_q      <= pf_d;
    end
  end

  assign bus.test_in   = test_in_q;
  assign bus.bist_mode = mode_q;
  assign bus.bist_end  = end_q;
  assign bus.pass_fail = pf_q;
`ifdef BIST_SIG_OUT_EN
  assign bus.signature = misr;
`endif

endmodule

// File: tb/tb_bist_ctrl_gen.sv
// Directed bench for bist_ctrl_gen: default engine with a registered stub CUT,
// plus a minimal instance (N_PAT=1, FLUSH=0, zero seed) driven from a vector table.
module tb_bist_ctrl_gen;

  localparam int N_PAT = 1000;
  localparam int FLUSH = 4;
  localparam int LAT   = N_PAT + FLUSH + 2;

  // Reference signature of the default engine feeding the registered stub CUT.
  function automatic logic [15:0] model_sig(input int n_pat, input int n_flush);
    logic [15:0] lf, ms;
    logic [2:0]  t, c;
    lf = 16'hACE1; ms = '0; t = '0; c = '0;
    for (int o = 0; o < 32; o++) begin
      for (int i = 0; i < 32; i++) begin
        if (o * 32 + i < n_pat + n_flush) begin
          ms = {ms[14:0], 1'b0} ^ (ms[15] ? 16'h1021 : 16'h0000) ^ {14'h0, c[1:0]};
          c  = t;
          if (o * 32 + i < n_pat) begin
            t  = lf[2:0];
            lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
          end else begin
            t = 3'b000;
          end
        end
      end
    end
    return ms;
  endfunction

  localparam logic [15:0] GOLD = model_sig(N_PAT, FLUSH);

  logic clk = 1'b0;
  logic rst_n;
  logic stuck;
  logic [2:0] cut_reg;
  logic [1:0] cut2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bist_ctrl_gen_if bus1 ();
  bist_ctrl_gen_if bus2 ();

  bist_ctrl_gen #(.GOLDEN(GOLD)) u_dut1 (.CLK(clk), .RST(rst_n), .bus(bus1));

  bist_ctrl_gen #(
    .LFSR_SEED(16'h0000), .N_PAT(1), .FLUSH(0), .GOLDEN(16'h0002)
  ) u_dut2 (.CLK(clk), .RST(rst_n), .bus(bus2));

  // Stub CUT: registered stimulus echoed back, with an injectable stuck-at-0 on bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cut_reg <= '0;
    else        cut_reg <= bus1.test_in;
  end
  assign bus1.cut_out = {cut_reg[1], cut_reg[0] & ~stuck};
  assign bus2.cut_out = cut2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is at a falling edge with bist_start low; rise is registered at the next edge.
  task automatic run1(input string tag, input logic exp_pf, input int pulse_at);
    logic [15:0] m;
    int bad;
    int cyc;
    m = 16'hACE1;
    bad = 0;
    cyc = 0;
    bus1.bist_start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_mode_k"}, {31'd0, bus1.bist_mode}, 32'd1);
    while (cyc < LAT + 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check({tag, "_end_clr"}, {31'd0, bus1.bist_end}, 32'd0);
      if (cyc >= 2 && cyc <= N_PAT + 1) begin
        if (bus1.test_in !== m[2:0]) bad++;
        m = (m >> 1) ^ (m[0] ? 16'hB400 : 16'h0000);
      end
      if (cyc < LAT && bus1.bist_mode !== 1'b1) bad++;
      if (pulse_at > 0 && cyc == pulse_at)     bus1.bist_start = 1'b0;
      if (pulse_at > 0 && cyc == pulse_at + 1) bus1.bist_start = 1'b1;
      if (bus1.bist_end === 1'b1) break;
    end
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_pass_fail"}, {31'd0, bus1.pass_fail}, {31'd0, exp_pf});
    check({tag, "_mode_off"}, {31'd0, bus1.bist_mode}, 32'd0);
    check({tag, "_seq_errs"}, bad, 0);
`ifdef BIST_SIG_OUT_EN
    if (exp_pf) check({tag, "_signature"}, {16'd0, bus1.signature}, {16'd0, GOLD});
`endif
  endtask

  typedef struct {
    logic [1:0]  cut;
    logic        exp_pf;
    logic [15:0] exp_sig;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{cut: 2'b10, exp_pf: 1'b1, exp_sig: 16'h0002};
    vecs[1] = '{cut: 2'b00, exp_pf: 1'b0, exp_sig: 16'h0000};
    vecs[2] = '{cut: 2'b11, exp_pf: 1'b0, exp_sig: 16'h0003};
    vecs[3] = '{cut: 2'b01, exp_pf: 1'b0, exp_sig: 16'h0001};

    rst_n = 1'b1;
    stuck = 1'b0;
    cut2 = 2'b00;
    bus1.bist_start = 1'b0;
    bus2.bist_start = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_dut1", {bus1.test_in, bus1.bist_mode, bus1.bist_end, bus1.pass_fail}, 0);
    check("rst_async_dut2", {bus2.test_in, bus2.bist_mode, bus2.bist_end, bus2.pass_fail}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("rst_idle", {bus1.test_in, bus1.bist_mode, bus1.bist_end, bus1.pass_fail}, 0);
    end

    // Pass path, start raised at t=300.
    while ($time < 300) @(negedge clk);
    run1("pass", 1'b1, 0);

    // Start held high in DONE: no restart.
    repeat (5) begin @(posedge clk); #1; end
    check("hold_end", {31'd0, bus1.bist_end}, 32'd1);
    check("hold_mode", {31'd0, bus1.bist_mode}, 32'd0);

    // Low-then-high in DONE restarts; a second rise during RUN is ignored.
    @(negedge clk) bus1.bist_start = 1'b0;
    @(negedge clk);
    run1("retrig", 1'b1, 100);

    // Fault detection.
    @(negedge clk) begin bus1.bist_start = 1'b0; stuck = 1'b1; end
    @(negedge clk);
    run1("fault", 1'b0, 0);
    stuck = 1'b0;

    // Reset mid-RUN at pattern 500.
    @(negedge clk) bus1.bist_start = 1'b0;
    @(negedge clk) bus1.bist_start = 1'b1;
    @(posedge clk);
    repeat (502) @(posedge clk);
    #3 begin rst_n = 1'b0; bus1.bist_start = 1'b0; end
    #1;
    check("midrst_async", {bus1.test_in, bus1.bist_mode, bus1.bist_end, bus1.pass_fail}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("midrst_idle", {bus1.bist_mode, bus1.bist_end}, 0);
    @(negedge clk);
    run1("rerun", 1'b1, 0);

    // Boundary instance: one pattern, no flush, zero seed loads 1.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk) begin bus2.bist_start = 1'b0; cut2 = vecs[v].cut; end
      @(negedge clk) bus2.bist_start = 1'b1;
      @(posedge clk); #1;
      check("b_mode_k", {31'd0, bus2.bist_mode}, 32'd1);
      @(posedge clk); #1;
      check("b_end_clr", {31'd0, bus2.bist_end}, 32'd0);
      @(posedge clk); #1;
      check("b_test_in", {29'd0, bus2.test_in}, 32'd1);
      check("b_end_early", {31'd0, bus2.bist_end}, 32'd0);
      @(posedge clk); #1;
      check("b_end", {31'd0, bus2.bist_end}, 32'd1);
      check("b_pass_fail", {31'd0, bus2.pass_fail}, {31'd0, vecs[v].exp_pf});
      check("b_mode_off", {31'd0, bus2.bist_mode}, 32'd0);
`ifdef BIST_SIG_OUT_EN
      check("b_signature", {16'd0, bus2.signature}, {16'd0, vecs[v].exp_sig});
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
